reg_access_ctrl: RTL and testbench
==================================

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 Single clock domain; reset asynchronous, active-high; all state changes on rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 wr_valid  in  1  write request present.
REQ-005 wr_ready  out  1  write request accepted this cycle when high with wr_valid.
REQ-006 wr_addr  in  4  destination register index.
REQ-007 wr_data  in  32  write data.
REQ-008 rd_valid  in  1  read request present.
REQ-009 rd_ready  out  1  read request accepted this cycle when high with rd_valid.
REQ-010 rd_addr_a / rd_addr_b  in  4 each  source register indices.
REQ-011 rsp_valid  out  1  read response held.
REQ-012 rsp_ready  in  1  consumer takes response.
REQ-013 rsp_data_a / rsp_data_b  out  32 each  read results.
REQ-014 Ra / Rb  out  4 each  register-memory read addresses.
REQ-015 Rd  out  4  register-memory write address.
REQ-016 DataInput  out  32  register-memory write data.
REQ-017 DataInputON  out  1  register-memory write enable; memory writes on rising clk edge when high.
REQ-018 Data1 / Data2  in  32 each  register-memory combinational read data for Ra / Rb.

Function
REQ-019 Write path: 4-entry FIFO of {addr, data}; push on wr_valid && wr_ready.
REQ-020 wr_ready = (count < 4); full FIFO refuses push even if popping same cycle.
REQ-021 Drain: DataInputON = (count != 0); Rd/DataInput = head entry; head popped on every edge where DataInputON is high (one write per cycle, FIFO order).
REQ-022 Push and pop in same cycle: count unchanged, pointers both advance; 2-bit pointers wrap 3 -> 0.
REQ-023 Ra = rd_addr_a, Rb = rd_addr_b, combinational pass-through.
REQ-024 Hazard: hazard = any valid FIFO entry (including head being drained) whose addr equals rd_addr_a or rd_addr_b; a write accepted in the current cycle does not count.
REQ-025 rd_ready = !hazard && (!rsp_valid || rsp_ready).
REQ-026 On rd_valid && rd_ready edge: rsp_data_a <= Data1, rsp_data_b <= Data2, rsp_valid <= 1 (latency 1 cycle).
REQ-027 rsp_valid clears on edge with rsp_ready high and no new read accepted; back-to-back reads with rsp_ready high sustain 1 response/cycle.
REQ-028 rsp_data_a/b stable while rsp_valid && !rsp_ready.
REQ-029 Reads and writes to different registers proceed in the same cycle independently.
REQ-030 Read of a register with pending write stalls until that entry drains; response then returns the written value.

Reset
REQ-031 While rst high: count, pointers, FIFO storage, rsp_valid, rsp_data_a/b = 0; hence DataInputON = 0, Rd = 0, DataInput = 0, wr_ready = 1.
REQ-032 Reset mid-operation discards all pending writes and any held response; no memory write occurs at or after assertion until new pushes.
REQ-033 First push accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Write 100 to r0, then 55 to r2 on consecutive cycles -> DataInputON high two consecutive cycles, Rd=0/DataInput=100 then Rd=2/DataInput=55.
REQ-035 Hold wr_valid 5 cycles with memory draining -> no stall; stall injection: 5 pushes in one burst without drain gap modelled by full FIFO -> wr_ready low at count=4, 5th accepted only after a pop frees space.
REQ-036 Write r3=0xDEADBEEF, same cycle next read a=3 b=1 -> rd_ready low until r3 drains; response rsp_data_a=0xDEADBEEF, rsp_data_b = r1 contents.
REQ-037 Read a=2 b=0 with rsp_ready low 3 cycles -> rsp_valid high, data constant, rd_ready low; rsp_ready high -> next read accepted same cycle.
REQ-038 Push 3 writes, assert rst for one cycle mid-drain -> DataInputON drops immediately, count=0, remaining writes never reach memory.

Source files
------------

// File: rtl/reg_access_ctrl_if.sv
// reg_access_ctrl_if
//   Bundles the write-request, read-request, read-response and
//   register-memory signals of reg_access_ctrl.
//   slave  : the controller side (reg_access_ctrl)
//   master : the requester / environment side
//   Write request : wr_valid, wr_ready, wr_addr[3:0], wr_data[31:0]
//   Read request  : rd_valid, rd_ready, rd_addr_a[3:0], rd_addr_b[3:0]
//   Read response : rsp_valid, rsp_ready, rsp_data_a[31:0], rsp_data_b[31:0]
//   Memory port   : Ra, Rb, Rd[3:0], DataInput[31:0], DataInputON,
//                   Data1, Data2[31:0]
interface reg_access_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data_a;
    logic [31:0] rsp_data_b;

    logic [3:0]  Ra;
    logic [3:0]  Rb;
    logic [3:0]  Rd;
    logic [31:0] DataInput;
    logic        DataInputON;
    logic [31:0] Data1;
    logic [31:0] Data2;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr_a, rd_addr_b,
        input  rsp_ready, Data1, Data2,
        output wr_ready, rd_ready, rsp_valid, rsp_data_a, rsp_data_b,
        output Ra, Rb, Rd, DataInput, DataInputON
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr_a, rd_addr_b,
        output rsp_ready, Data1, Data2,
        input  wr_ready, rd_ready, rsp_valid, rsp_data_a, rsp_data_b,
        input  Ra, Rb, Rd, DataInput, DataInputON
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl
//   Register-file access controller. Writes are queued in a 4-entry FIFO
//   and drained into the register memory one per cycle. Reads are passed
//   straight to the memory read ports and the result is registered into a
//   response holding stage. A read whose source register still has a
//   queued write is stalled until that write has drained.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous active-high reset
//     bus  - reg_access_ctrl_if.slave (request, response and memory port)
module reg_access_ctrl (
    input  logic              clk,
    input  logic              rst,
    reg_access_ctrl_if.slave  bus
);

    logic [3:0]  fifoAddr [4];
    logic [31:0] fifoData [4];
    logic [1:0]  wrPtr;
    logic [1:0]  rdPtr;
    logic [2:0]  count;

    logic        rspValid;
    logic [31:0] rspDataA;
    logic [31:0] rspDataB;

    logic        pushEn;
    logic        popEn;
    logic        hazard;
    logic        wrReady;
    logic        rdReady;
    logic        rdAccept;

    always_comb begin
        wrReady  = (count < 3'd4);
        popEn    = (count != 3'd0);
        pushEn   = bus.wr_valid && wrReady;
        rdReady  = !hazard && (!rspValid || bus.rsp_ready);
        rdAccept = bus.rd_valid && rdReady;
    end

    // An entry is live when its distance from the head is below count;
    // with count == 4 every slot is live.
    always_comb begin
        logic [1:0] offset;
        hazard = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            offset = 2'(i) - rdPtr;
            if (({1'b0, offset} < count) &&
                ((fifoAddr[i] == bus.rd_addr_a) || (fifoAddr[i] == bus.rd_addr_b)))
                hazard = 1'b1;
        end
    end

    assign bus.wr_ready    = wrReady;
    assign bus.rd_ready    = rdReady;
    assign bus.rsp_valid   = rspValid;
    assign bus.rsp_data_a  = rspDataA;
    assign bus.rsp_data_b  = rspDataB;
    assign bus.Ra          = bus.rd_addr_a;
    assign bus.Rb          = bus.rd_addr_b;
    assign bus.Rd          = fifoAddr[rdPtr];
    assign bus.DataInput   = fifoData[rdPtr];
    assign bus.DataInputON = popEn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                fifoAddr[i] <= '0;
                fifoData[i] <= '0;
            end
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            rspValid <= 1'b0;
            rspDataA <= '0;
            rspDataB <= '0;
        end else begin
            if (pushEn) begin
                fifoAddr[wrPtr] <= bus.wr_addr;
                fifoData[wrPtr] <= bus.wr_data;
                wrPtr           <= wrPtr + 2'd1;
            end
            if (popEn)
                rdPtr <= rdPtr + 2'd1;

            case ({pushEn, popEn})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (rdAccept) begin
                rspValid <= 1'b1;
                rspDataA <= bus.Data1;
                rspDataB <= bus.Data2;
            end else if (bus.rsp_ready) begin
                rspValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
module tb_reg_access_ctrl;

    logic clk;
    logic rst;

    reg_access_ctrl_if intf ();

    reg_access_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register memory seen by the DUT: combinational read, write on clk edge.
    logic [31:0] mem [16];
    assign intf.Data1 = mem[intf.Ra];
    assign intf.Data2 = mem[intf.Rb];
    always @(posedge clk) begin
        if (intf.DataInputON)
            mem[intf.Rd] <= intf.DataInput;
    end

    // Reference model: pending writes in order, expected register contents,
    // and the held response.
    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         pend [$];
    logic [31:0] refMem [16];
    logic        mRspV;
    logic [31:0] mRspA;
    logic [31:0] mRspB;

    int cmpCount;
    int errCount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance.
    task automatic step(input logic r, input logic wv, input logic [3:0] wa,
                        input logic [31:0] wd, input logic rv,
                        input logic [3:0] ra, input logic [3:0] rb, input logic rr);
        logic expWrRdy;
        logic expRdRdy;
        logic haz;
        rst            = r;
        intf.wr_valid  = wv;
        intf.wr_addr   = wa;
        intf.wr_data   = wd;
        intf.rd_valid  = rv;
        intf.rd_addr_a = ra;
        intf.rd_addr_b = rb;
        intf.rsp_ready = rr;
        #1;
        if (r) begin
            pend.delete();
            mRspV = 1'b0;
            mRspA = '0;
            mRspB = '0;
        end
        expWrRdy = (pend.size() < 4);
        haz = 1'b0;
        foreach (pend[i])
            if (pend[i].a == ra || pend[i].a == rb) haz = 1'b1;
        expRdRdy = !haz && (!mRspV || rr);

        chk("wr_ready", {31'd0, intf.wr_ready}, {31'd0, expWrRdy});
        chk("rd_ready", {31'd0, intf.rd_ready}, {31'd0, expRdRdy});
        chk("DataInputON", {31'd0, intf.DataInputON}, {31'd0, pend.size() != 0});
        chk("Ra", {28'd0, intf.Ra}, {28'd0, ra});
        chk("Rb", {28'd0, intf.Rb}, {28'd0, rb});
        chk("rsp_valid", {31'd0, intf.rsp_valid}, {31'd0, mRspV});
        chk("rsp_data_a", intf.rsp_data_a, mRspA);
        chk("rsp_data_b", intf.rsp_data_b, mRspB);
        if (r) begin
            chk("Rd_rst", {28'd0, intf.Rd}, 32'd0);
            chk("DataInput_rst", intf.DataInput, 32'd0);
        end else if (pend.size() != 0) begin
            chk("Rd", {28'd0, intf.Rd}, {28'd0, pend[0].a});
            chk("DataInput", intf.DataInput, pend[0].d);
        end

        if (!r) begin
            if (rv && expRdRdy) begin
                mRspV = 1'b1;
                mRspA = refMem[ra];
                mRspB = refMem[rb];
            end else if (rr) begin
                mRspV = 1'b0;
            end
            if (pend.size() != 0) begin
                refMem[pend[0].a] = pend[0].d;
                void'(pend.pop_front());
            end
            if (wv && expWrRdy)
                pend.push_back('{a: wa, d: wd});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        cmpCount = 0;
        errCount = 0;
        mRspV = 1'b0;
        mRspA = '0;
        mRspB = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]    = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            refMem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end
        rst = 1'b1;
        intf.wr_valid = 1'b0; intf.wr_addr = '0; intf.wr_data = '0;
        intf.rd_valid = 1'b0; intf.rd_addr_a = '0; intf.rd_addr_b = '0;
        intf.rsp_ready = 1'b1;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 5, 32'h5555, 1, 5, 6, 1);

        // Two consecutive writes drain in order
        step(0, 1, 4'd0, 32'd100, 0, 4'd9, 4'd9, 1);
        step(0, 1, 4'd2, 32'd55,  0, 4'd9, 4'd9, 1);
        step(0, 0, 0, 0, 0, 4'd9, 4'd9, 1);
        step(0, 0, 0, 0, 0, 4'd9, 4'd9, 1);

        // Five held writes while draining: no stall
        for (int i = 0; i < 5; i++)
            step(0, 1, 4'(i + 5), 32'hA000 + 32'(i), 0, 4'd15, 4'd15, 1);
        step(0, 0, 0, 0, 0, 4'd15, 4'd15, 1);

        // Read hits a pending write: stall, then the written value returns
        step(0, 1, 4'd3, 32'hDEADBEEF, 0, 4'd3, 4'd1, 1);
        step(0, 0, 0, 0, 1, 4'd3, 4'd1, 1);
        step(0, 0, 0, 0, 1, 4'd3, 4'd1, 1);
        step(0, 0, 0, 0, 0, 4'd3, 4'd1, 1);

        // Response held under backpressure, then back-to-back read
        step(0, 0, 0, 0, 1, 4'd2, 4'd0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 1, 4'd4, 4'd5, 0);
        step(0, 0, 0, 0, 1, 4'd6, 4'd7, 1);
        step(0, 0, 0, 0, 0, 4'd6, 4'd7, 1);

        // Reset mid-drain discards pending writes and the held response
        step(0, 0, 0, 0, 1, 4'd8, 4'd8, 0);
        step(0, 1, 4'd10, 32'h1111, 0, 4'd8, 4'd8, 0);
        step(0, 1, 4'd11, 32'h2222, 0, 4'd8, 4'd8, 0);
        step(0, 1, 4'd12, 32'h3333, 0, 4'd8, 4'd8, 0);
        step(1, 0, 0, 0, 0, 4'd10, 4'd11, 1);
        step(0, 1, 4'd13, 32'h4444, 1, 4'd11, 4'd12, 1);
        step(0, 0, 0, 0, 1, 4'd13, 4'd10, 1);
        step(0, 0, 0, 0, 0, 4'd13, 4'd10, 1);

        // Randomised traffic over a small address range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)),
                 $urandom,
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
